// File: rtl/sun_pll_lock.sv
`default_nettype none
//------------------------------------------------------------------------------
// sun_pll_lock - CK_REF period lock detector running on the PLL output clock.
// Rev 1.0
//------------------------------------------------------------------------------
module sun_pll_lock #(
  parameter int DIV          = 32,
  parameter int TOL          = 1,
  parameter int LOCK_CNT     = 8,
  parameter int TIMEOUT_REFS = 255,
  parameter int CNT_W        = 8
) (
  input  logic             CK,
  input  logic             PWRUP_1V8,
  input  logic             CK_REF,
  input  logic             CLR_LOCK,
  output logic             LOCKED,
  output logic             LOCK_LOST,
  output logic             TIMEOUT,
  output logic [CNT_W-1:0] PERIOD,
  output logic             PERIOD_VLD
);

  localparam int GOOD_W = $clog2(LOCK_CNT + 1);
  localparam int WIN_W  = $clog2(TIMEOUT_REFS + 1);

  localparam logic [CNT_W-1:0]  c_max       = '1;
  localparam logic [CNT_W-1:0]  c_lo        = CNT_W'(DIV - TOL);
  localparam logic [CNT_W-1:0]  c_hi        = CNT_W'(DIV + TOL);
  localparam logic [GOOD_W-1:0] c_good_last = GOOD_W'(LOCK_CNT - 1);
  localparam logic [WIN_W-1:0]  c_win_last  = WIN_W'(TIMEOUT_REFS - 1);
  localparam logic [WIN_W-1:0]  c_win_max   = WIN_W'(TIMEOUT_REFS);

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_ACQ  = 2'd1,
    ST_LOCK = 2'd2
  } state_t;

  logic              r_s1, r_s2, r_s3;
  state_t            r_state;
  logic [CNT_W-1:0]  r_cnt;
  logic [GOOD_W-1:0] r_good;
  logic [WIN_W-1:0]  r_win;
  logic              r_locked, r_lost, r_timeout, r_vld;
  logic [CNT_W-1:0]  r_period;

  logic              w_edge, w_sat, w_good;
  logic [CNT_W-1:0]  w_meas;

  assign w_edge = r_s2 & ~r_s3;
  assign w_sat  = (r_cnt == c_max);
  assign w_meas = w_sat ? c_max : r_cnt + CNT_W'(1);
  assign w_good = (w_meas >= c_lo) && (w_meas <= c_hi);

  // s1/s2 resolve metastability; s3 only serves the rising-edge detect
  always_ff @(posedge CK or negedge PWRUP_1V8) begin
    if (!PWRUP_1V8) begin
      r_s1 <= 1'b0;
      r_s2 <= 1'b0;
      r_s3 <= 1'b0;
    end else begin
      r_s1 <= CK_REF;
      r_s2 <= r_s1;
      r_s3 <= r_s2;
    end
  end

  always_ff @(posedge CK or negedge PWRUP_1V8) begin
    if (!PWRUP_1V8) begin
      r_state   <= ST_IDLE;
      r_cnt     <= '0;
      r_good    <= '0;
      r_win     <= '0;
      r_locked  <= 1'b0;
      r_lost    <= 1'b0;
      r_timeout <= 1'b0;
      r_period  <= '0;
      r_vld     <= 1'b0;
    end else begin
      r_vld <= 1'b0;
      if (CLR_LOCK) begin
        // an edge coinciding with the restart is deliberately dropped
        r_state   <= ST_IDLE;
        r_cnt     <= '0;
        r_good    <= '0;
        r_win     <= '0;
        r_locked  <= 1'b0;
        r_lost    <= 1'b0;
        r_timeout <= 1'b0;
        r_period  <= '0;
      end else begin
        if (r_state != ST_IDLE) begin
          if (w_edge)
            r_cnt <= '0;
          else if (!w_sat)
            r_cnt <= r_cnt + CNT_W'(1);
        end
        case (r_state)
          ST_IDLE: begin
            r_cnt <= '0;
            if (w_edge)
              r_state <= ST_ACQ;
          end
          ST_ACQ: begin
            if (w_edge) begin
              r_period <= w_meas;
              r_vld    <= 1'b1;
              if (r_win != c_win_max) begin
                r_win <= r_win + WIN_W'(1);
                if (r_win == c_win_last)
                  r_timeout <= 1'b1;
              end
              if (!w_good) begin
                r_good <= '0;
              end else if (r_good == c_good_last) begin
                r_good   <= '0;
                r_state  <= ST_LOCK;
                r_locked <= 1'b1;
              end else begin
                r_good <= r_good + GOOD_W'(1);
              end
            end
          end
          ST_LOCK: begin
            // saturation without an edge means the reference vanished
            if (w_edge || w_sat) begin
              r_period <= w_meas;
              r_vld    <= 1'b1;
              if (!w_edge || !w_good) begin
                r_lost   <= 1'b1;
                r_locked <= 1'b0;
                r_state  <= ST_ACQ;
                r_good   <= '0;
                r_win    <= '0;
              end
            end
          end
          default: r_state <= ST_IDLE;
        endcase
      end
    end
  end

  assign LOCKED     = r_locked;
  assign LOCK_LOST  = r_lost;
  assign TIMEOUT    = r_timeout;
  assign PERIOD     = r_period;
  assign PERIOD_VLD = r_vld;

endmodule
`default_nettype wire
